// File: rtl/imem_loader_if.sv
// Loader-side bus: UART byte strobe in, CPU fetch port and status out.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [15:0] imem_addr_in;
  logic [31:0] imem_rd_data_out;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  modport master (
    output rx_valid, rx_data, imem_addr_in,
    input  imem_rd_data_out, cpu_rst, load_done, load_err
  );

  modport slave (
    input  rx_valid, rx_data, imem_addr_in,
    output imem_rd_data_out, cpu_rst, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loaded over a UART byte stream (MAGIC, 16-bit word count,
// little-endian words, XOR checksum); holds the CPU in reset until verified.
module imem_loader #(
  parameter int         DEPTH_LOG2 = 12,
  parameter logic [7:0] MAGIC      = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, RUN} state_e;

  state_e      state_q;
  logic [7:0]  len_lo_q, csum_q;
  logic [15:0] n_q, wptr_q;
  logic [1:0]  bcnt_q;
  logic [23:0] word_q;
  logic        cpu_rst_q, load_done_q, load_err_q;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  logic [15:0]           len_c;
  logic                  len_bad_c;
  logic                  we_c;
  logic [31:0]           wdata_c;
  logic [DEPTH_LOG2-1:0] raddr_c;
  logic                  unused_addr;

  assign len_c     = {bus.rx_data, len_lo_q};
  assign len_bad_c = (len_c == 16'd0) || ({16'd0, len_c} > 32'(DEPTH));
  assign we_c      = bus.rx_valid && (state_q == DATA) && (bcnt_q == 2'd3);
  // Earlier three bytes already sit in word_q; the 4th goes straight to the top.
  assign wdata_c   = {bus.rx_data, word_q};
  assign raddr_c   = bus.imem_addr_in[DEPTH_LOG2+1:2];
  assign unused_addr = ^bus.imem_addr_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_lo_q    <= '0;
      n_q         <= '0;
      wptr_q      <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else if (bus.rx_valid) begin
      case (state_q)
        IDLE: if (bus.rx_data == MAGIC) begin
          state_q    <= LEN0;
          load_err_q <= 1'b0;
        end
        LEN0: begin
          len_lo_q <= bus.rx_data;
          state_q  <= LEN1;
        end
        LEN1: if (len_bad_c) begin
          load_err_q <= 1'b1;
          state_q    <= IDLE;
        end else begin
          n_q     <= len_c;
          wptr_q  <= '0;
          bcnt_q  <= '0;
          csum_q  <= '0;
          state_q <= DATA;
        end
        DATA: begin
          csum_q <= csum_q ^ bus.rx_data;
          bcnt_q <= bcnt_q + 2'd1;
          word_q <= {bus.rx_data, word_q[23:8]};
          if (bcnt_q == 2'd3) begin
            wptr_q <= wptr_q + 16'd1;
            if (wptr_q == n_q - 16'd1) state_q <= CSUM;
          end
        end
        CSUM: if (bus.rx_data == csum_q) begin
          state_q     <= RUN;
          cpu_rst_q   <= 1'b0;
          load_done_q <= 1'b1;
        end else begin
          state_q    <= IDLE;
          load_err_q <= 1'b1;
        end
        RUN: if (bus.rx_data == MAGIC) begin
          state_q     <= LEN0;
          cpu_rst_q   <= 1'b1;
          load_done_q <= 1'b0;
          load_err_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Unreset simple dual-port array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_c) mem[wptr_q[DEPTH_LOG2-1:0]] <= wdata_c;
    rd_q <= mem[raddr_c];
  end

  assign bus.imem_rd_data_out = cpu_rst_q ? NOP : rd_q;
  assign bus.cpu_rst          = cpu_rst_q;
  assign bus.load_done        = load_done_q;
  assign bus.load_err         = load_err_q;
endmodule
